// File: rtl/ddr2_24x64_8_ex_rd_checker.sv
// DDR2 example read-data checker: regenerates per-lane LFSR data, compares beats, reports status.
// Optional first-fail capture is enabled by defining DDR2_EX_RD_CHECKER_FIRST_FAIL_EN.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for start; rdata_valid ignored, LFSRs hold
// RUN   | accepting beats until num_beats have been taken
module ddr2_24x64_8_ex_rd_checker #(
  parameter int SEED      = 32,
  parameter int NUM_LANES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            num_beats,
  input  logic [8*NUM_LANES-1:0] rdata,
  input  logic                   rdata_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   pnf,
  output logic [NUM_LANES-1:0]   lane_fail,
  output logic [15:0]            err_count,
  output logic [8*NUM_LANES-1:0] first_fail_data,
  output logic [15:0]            first_fail_beat
);

  localparam int DW = 8 * NUM_LANES;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [DW-1:0] seed_word();
    logic [DW-1:0] w;
    int            s;
    w = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      s = SEED + i;
      w[8*i +: 8] = s[7:0];
    end
    return w;
  endfunction

  localparam logic [DW-1:0] SEED_WORD = seed_word();

  logic [0:0]           state_q, state_d;
  logic [DW-1:0]        lfsr_q, lfsr_d, lfsr_step;
  logic [15:0]          beat_cnt_q, beat_cnt_d;
  logic [15:0]          nb_q, nb_d;
  logic [NUM_LANES-1:0] lane_fail_q, lane_fail_d;
  logic [15:0]          err_count_q, err_count_d;
  logic                 done_q, done_d;
  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_last_q, s1_last_d;
  logic [NUM_LANES-1:0] s1_mism_q, s1_mism_d;
  logic [NUM_LANES-1:0] mism;
  logic                 accept;

  always_comb begin
    lfsr_step = '0;
    mism      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lfsr_step[8*i +: 8] = {lfsr_q[8*i+6], lfsr_q[8*i+5], lfsr_q[8*i+4],
                             lfsr_q[8*i+3] ^ lfsr_q[8*i+7],
                             lfsr_q[8*i+2] ^ lfsr_q[8*i+7],
                             lfsr_q[8*i+1] ^ lfsr_q[8*i+7],
                             lfsr_q[8*i+0], lfsr_q[8*i+7]};
      mism[i] = rdata[8*i +: 8] != lfsr_q[8*i +: 8];
    end
  end

  // Once the final beat is taken the counter equals nb_q, which blocks further beats
  // while its compare result drains through the status stage.
  assign accept = (state_q == RUN) && rdata_valid && !start && (beat_cnt_q != nb_q);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    beat_cnt_d  = beat_cnt_q;
    nb_d        = nb_q;
    lane_fail_d = lane_fail_q;
    err_count_d = err_count_q;
    done_d      = 1'b0;
    s1_vld_d    = 1'b0;
    s1_last_d   = 1'b0;
    s1_mism_d   = '0;
    if (start) begin
      lfsr_d      = SEED_WORD;
      beat_cnt_d  = '0;
      nb_d        = num_beats;
      lane_fail_d = '0;
      err_count_d = '0;
      if (num_beats == 16'd0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      s1_vld_d  = accept;
      s1_last_d = accept && (beat_cnt_q == nb_q - 16'd1);
      s1_mism_d = accept ? mism : '0;
      if (accept) begin
        lfsr_d     = lfsr_step;
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
      if (s1_vld_q) begin
        lane_fail_d = lane_fail_q | s1_mism_q;
        if ((|s1_mism_q) && (err_count_q != 16'hFFFF)) begin
          err_count_d = err_count_q + 16'd1;
        end
        if (s1_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_WORD;
      beat_cnt_q  <= '0;
      nb_q        <= '0;
      lane_fail_q <= '0;
      err_count_q <= '0;
      done_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mism_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      beat_cnt_q  <= beat_cnt_d;
      nb_q        <= nb_d;
      lane_fail_q <= lane_fail_d;
      err_count_q <= err_count_d;
      done_q      <= done_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_mism_q   <= s1_mism_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign pnf       = ~|lane_fail_q;
  assign lane_fail = lane_fail_q;
  assign err_count = err_count_q;

`ifdef DDR2_EX_RD_CHECKER_FIRST_FAIL_EN
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [15:0]   s1_beat_q, s1_beat_d;
  logic [DW-1:0] ff_data_q, ff_data_d;
  logic [15:0]   ff_beat_q, ff_beat_d;
  logic          ff_vld_q, ff_vld_d;

  // Capture is armed by start and latches only the first failing beat.
  always_comb begin
    s1_data_d = accept ? rdata : s1_data_q;
    s1_beat_d = accept ? beat_cnt_q : s1_beat_q;
    ff_data_d = ff_data_q;
    ff_beat_d = ff_beat_q;
    ff_vld_d  = ff_vld_q;
    if (start) begin
      ff_data_d = '0;
      ff_beat_d = '0;
      ff_vld_d  = 1'b0;
    end else if (s1_vld_q && (|s1_mism_q) && !ff_vld_q) begin
      ff_data_d = s1_data_q;
      ff_beat_d = s1_beat_q;
      ff_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q <= '0;
      s1_beat_q <= '0;
      ff_data_q <= '0;
      ff_beat_q <= '0;
      ff_vld_q  <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_beat_q <= s1_beat_d;
      ff_data_q <= ff_data_d;
      ff_beat_q <= ff_beat_d;
      ff_vld_q  <= ff_vld_d;
    end
  end

  assign first_fail_data = ff_data_q;
  assign first_fail_beat = ff_beat_q;
`else
  assign first_fail_data = '0;
  assign first_fail_beat = '0;
`endif

endmodule

// File: tb/tb_ddr2_24x64_8_ex_rd_checker.sv
// Bench for ddr2_24x64_8_ex_rd_checker: table-driven cycle vectors plus hand-written corner sequences.
`timescale 1ns/1ps

module tb_ddr2_24x64_8_ex_rd_checker;

  localparam int SEED = 32;
  localparam int NL   = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_beats = '0;
  logic [63:0]   rdata = '0;
  logic          rdata_valid = 1'b0;
  logic          busy, done, pnf;
  logic [7:0]    lane_fail;
  logic [15:0]   err_count;
  logic [63:0]   first_fail_data;
  logic [15:0]   first_fail_beat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr2_24x64_8_ex_rd_checker #(.SEED(SEED), .NUM_LANES(NL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_beats(num_beats),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .pnf(pnf), .lane_fail(lane_fail), .err_count(err_count),
    .first_fail_data(first_fail_data), .first_fail_beat(first_fail_beat)
  );

  typedef struct {
    logic        st;
    logic        vl;
    logic [15:0] nb;
    int          beat;
    logic [63:0] xm;
    logic        e_busy;
    logic        e_done;
    logic        e_pnf;
    logic [7:0]  e_lf;
    logic [15:0] e_ec;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    logic [7:0] n;
    n[0] = d[7];
    n[1] = d[0];
    n[2] = d[1] ^ d[7];
    n[3] = d[2] ^ d[7];
    n[4] = d[3] ^ d[7];
    n[5] = d[4];
    n[6] = d[5];
    n[7] = d[6];
    return n;
  endfunction

  function automatic logic [63:0] exp_word(input int beat);
    logic [63:0] w;
    logic [7:0]  v;
    int          s;
    for (int i = 0; i < NL; i++) begin
      s = (SEED + i) % 256;
      v = s[7:0];
      for (int b = 0; b < beat; b++) v = lfsr_next(v);
      w[8*i +: 8] = v;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vl, input logic [15:0] nb, input int beat,
                     input logic [63:0] xm, input logic eb, input logic ed, input logic ep,
                     input logic [7:0] elf, input logic [15:0] eec);
    vec_t v;
    v.st = st; v.vl = vl; v.nb = nb; v.beat = beat; v.xm = xm;
    v.e_busy = eb; v.e_done = ed; v.e_pnf = ep; v.e_lf = elf; v.e_ec = eec;
    vecs.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start       = vecs[i].st;
      rdata_valid = vecs[i].vl;
      num_beats   = vecs[i].nb;
      rdata       = exp_word(vecs[i].beat) ^ vecs[i].xm;
      @(posedge clk);
      #1;
      start = 1'b0;
      rdata_valid = 1'b0;
      chk($sformatf("row%0d busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
      chk($sformatf("row%0d done", i), {63'd0, done}, {63'd0, vecs[i].e_done});
      chk($sformatf("row%0d pnf", i), {63'd0, pnf}, {63'd0, vecs[i].e_pnf});
      chk($sformatf("row%0d lane_fail", i), {56'd0, lane_fail}, {56'd0, vecs[i].e_lf});
      chk($sformatf("row%0d err_count", i), {48'd0, err_count}, {48'd0, vecs[i].e_ec});
`ifndef DDR2_EX_RD_CHECKER_FIRST_FAIL_EN
      chk($sformatf("row%0d ff_data_zero", i), first_fail_data, 64'd0);
`endif
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd0);
    chk({tag, " pnf"}, {63'd0, pnf}, 64'd1);
    chk({tag, " lane_fail"}, {56'd0, lane_fail}, 64'd0);
    chk({tag, " err_count"}, {48'd0, err_count}, 64'd0);
    chk({tag, " ff_data"}, first_fail_data, 64'd0);
    chk({tag, " ff_beat"}, {48'd0, first_fail_beat}, 64'd0);
  endtask

  localparam logic [63:0] ONES = '1;

  initial begin
    int got_done;

    // clean pass, 4 beats (rows 0-6)
    add(1,0,4,0,0,             1,0,1,8'h00,0);
    add(0,1,0,0,0,             1,0,1,8'h00,0);
    add(0,1,0,1,0,             1,0,1,8'h00,0);
    add(0,1,0,2,0,             1,0,1,8'h00,0);
    add(0,1,0,3,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             0,1,1,8'h00,0);
    add(0,0,0,0,0,             0,0,1,8'h00,0);
    // lane3 bit0 flipped on beat 2 (rows 7-13)
    add(1,0,4,0,0,             1,0,1,8'h00,0);
    add(0,1,0,0,0,             1,0,1,8'h00,0);
    add(0,1,0,1,0,             1,0,1,8'h00,0);
    add(0,1,0,2,64'h1 << 24,   1,0,1,8'h00,0);
    add(0,1,0,3,0,             1,0,0,8'h08,1);
    add(0,0,0,0,0,             0,1,0,8'h08,1);
    add(0,0,0,0,0,             0,0,0,8'h08,1);
    // idle junk, then gapped 3-beat pass (rows 14-23)
    add(0,1,0,5,ONES,          0,0,0,8'h08,1);
    add(0,1,0,0,ONES,          0,0,0,8'h08,1);
    add(1,0,3,0,0,             1,0,1,8'h00,0);
    add(0,1,0,0,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             1,0,1,8'h00,0);
    add(0,1,0,1,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             1,0,1,8'h00,0);
    add(0,1,0,2,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             0,1,1,8'h00,0);
    // 1-beat fail then start colliding with a garbage beat (rows 24-30)
    add(1,0,1,0,0,             1,0,1,8'h00,0);
    add(0,1,0,0,64'hFF,        1,0,1,8'h00,0);
    add(0,0,0,0,0,             0,1,0,8'h01,1);
    add(1,1,2,0,ONES,          1,0,1,8'h00,0);
    add(0,1,0,0,0,             1,0,1,8'h00,0);
    add(0,1,0,1,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             0,1,1,8'h00,0);
    // restart in the middle of RUN (rows 31-36)
    add(1,0,3,0,0,             1,0,1,8'h00,0);
    add(0,1,0,0,ONES,          1,0,1,8'h00,0);
    add(0,1,0,1,0,             1,0,0,8'hFF,1);
    add(1,1,1,2,0,             1,0,1,8'h00,0);
    add(0,1,0,0,0,             1,0,1,8'h00,0);
    add(0,0,0,0,0,             0,1,1,8'h00,0);
    // num_beats=0, both from pass and from fail status (rows 37-43)
    add(1,0,0,0,0,             0,1,1,8'h00,0);
    add(0,1,0,0,ONES,          0,0,1,8'h00,0);
    add(1,0,1,0,0,             1,0,1,8'h00,0);
    add(0,1,0,0,64'h0F00,      1,0,1,8'h00,0);
    add(0,0,0,0,0,             0,1,0,8'h02,1);
    add(1,0,0,0,0,             0,1,1,8'h00,0);
    add(0,0,0,0,0,             0,0,1,8'h00,0);

    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("post_reset");

    run_rows(0, 13);
`ifdef DDR2_EX_RD_CHECKER_FIRST_FAIL_EN
    chk("ff_beat after lane3 error", {48'd0, first_fail_beat}, 64'd2);
    chk("ff_data after lane3 error", first_fail_data, exp_word(2) ^ (64'h1 << 24));
`else
    chk("ff_beat disabled", {48'd0, first_fail_beat}, 64'd0);
`endif
    run_rows(14, 30);
`ifdef DDR2_EX_RD_CHECKER_FIRST_FAIL_EN
    chk("ff_beat cleared by restart", {48'd0, first_fail_beat}, 64'd0);
    chk("ff_data cleared by restart", first_fail_data, 64'd0);
`endif
    run_rows(31, vecs.size() - 1);

    // saturation: 65535 beats of zero data never match a nonzero-seeded LFSR
    start = 1'b1;
    num_beats = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    rdata = '0;
    rdata_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    rdata_valid = 1'b0;
    got_done = 0;
    for (int c = 0; c < 4 && got_done == 0; c++) begin
      @(posedge clk);
      #1;
      if (done) got_done = 1;
    end
    chk("sat done seen", 64'(got_done), 64'd1);
    chk("sat err_count", {48'd0, err_count}, 64'hFFFF);
    chk("sat lane_fail", {56'd0, lane_fail}, 64'hFF);
    chk("sat pnf", {63'd0, pnf}, 64'd0);
    chk("sat busy", {63'd0, busy}, 64'd0);
`ifdef DDR2_EX_RD_CHECKER_FIRST_FAIL_EN
    chk("sat ff_beat", {48'd0, first_fail_beat}, 64'd0);
`endif

    // async reset in the middle of a failing run
    start = 1'b1;
    num_beats = 16'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    rdata_valid = 1'b1;
    rdata = exp_word(0) ^ ONES;
    @(posedge clk);
    #1;
    rdata = exp_word(1);
    @(posedge clk);
    #1;
    rdata = exp_word(2);
    chk("pre_reset lane_fail", {56'd0, lane_fail}, 64'hFF);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    rdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    got_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) got_done = 1;
    end
    chk("no done/busy after reset", 64'(got_done), 64'd0);

    // a fresh 1-beat run after reset still passes
    start = 1'b1;
    num_beats = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rdata_valid = 1'b1;
    rdata = exp_word(0);
    @(posedge clk);
    #1;
    rdata_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset run done", {63'd0, done}, 64'd1);
    chk("post_reset run pnf", {63'd0, pnf}, 64'd1);
    chk("post_reset run err_count", {48'd0, err_count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr2_24x64_8_ex_rd_checker.md
# ddr2_24x64_8_ex_rd_checker

Read-data checker for the DDR2 24x64 example driver: the stage directly downstream of the per-byte 8-bit LFSR pattern generators. The driver writes LFSR patterns to memory. This block regenerates the identical expected sequence per byte lane, compares it beat by beat against returned read data, and reports sticky per-lane failures, a saturating error count, and test completion. Optionally, it also captures the first failing beat.

## Interface
Parameters:
- SEED, 32, base seed; lane i seeds with (SEED + i) mod 256; must match the write-side generators.
- NUM_LANES, 8, byte lanes; data width = 8*NUM_LANES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins/restarts a test.
- num_beats  in  16  beats to check; sampled on start.
- rdata  in  8*NUM_LANES  read data; lane i = rdata[8i+7:8i].
- rdata_valid  in  1  rdata valid this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at test completion.
- pnf  out  1  pass-not-fail; low if any lane_fail bit is set.
- lane_fail  out  NUM_LANES  sticky per-lane mismatch flags.
- err_count  out  16  count of mismatching beats, saturating at 0xFFFF.
- first_fail_data  out  8*NUM_LANES  rdata of first failing beat.
- first_fail_beat  out  16  index (0-based) of first failing beat.

## Operation
- Expected generator per lane: 8-bit LFSR. Next state: n0=d7, n1=d0, n2=d1^d7, n3=d2^d7, n4=d3^d7, n5=d4, n6=d5, n7=d6.
- FSM states: IDLE, RUN.
  - IDLE --start--> RUN. In RUN, start again restarts the test (same actions as from IDLE). RUN --final beat accepted--> IDLE.
- Actions on start, in any state:
  - Load all LFSRs with their seeds.
  - Clear lane_fail, err_count, beat counter, and first-fail capture.
  - Latch num_beats.
- In RUN, each cycle with rdata_valid=1, one beat is accepted:
  - Compare each lane of rdata against its LFSR. Mismatching lanes set their lane_fail bit.
  - If any lane mismatches, err_count increments, holding at 0xFFFF.
  - Advance all LFSRs one step.
  - Increment the beat counter.
- When the accepted beat is number num_beats (the last beat), the block pulses done and returns to IDLE.
- If num_beats=0 at start, the block does not enter RUN. done pulses the cycle after start, with pnf=1.
- rdata_valid in IDLE is ignored; LFSRs hold.
- start and rdata_valid in the same cycle: start wins, and that beat is discarded.
- Status outputs hold after done until the next start.

## Timing
- Reset values:
  - busy=0, done=0, pnf=1, lane_fail=0, err_count=0, first_fail_data=0, first_fail_beat=0.
  - State is IDLE and LFSRs hold their seeds.
- Reset asserted mid-test aborts immediately to reset values. No done is produced.
- start at edge N gives busy=1 from N+1.
- Latency: a beat accepted at edge N is reflected in lane_fail, err_count, and pnf after edge N+1 (registered compare).
- For the final beat accepted at edge N: done=1 and busy=0 after edge N+1, with status already including that beat.
- Back-to-back rdata_valid is supported at one beat per clock with no stall; the block never backpressures.

## Configuration
- Macro DDR2_EX_RD_CHECKER_FIRST_FAIL_EN.
- Defined: on the first mismatching beat after start, latch first_fail_data=rdata and first_fail_beat=beat index. These hold until the next start or reset; later failures do not overwrite them.
- Undefined: no capture registers are built. first_fail_data and first_fail_beat are constant 0.

## Test plan
- Clean pass: SEED=32, start with num_beats=4. Drive four consecutive beats with lane0=0x20,0x40,0x80,0x1D and lane1=0x21,0x42,0x84,0x15 (other lanes per the LFSR). Required: done one cycle after the 4th beat, pnf=1, err_count=0, lane_fail=0.
- Single lane error: same as the clean pass, but beat 2 has lane3 bit0 flipped. Required: lane_fail=0x08, err_count=1, pnf=0. With the macro defined: first_fail_beat=2 and first_fail_data equals the corrupted word.
- Gapped valid plus IDLE junk: pulse rdata_valid with garbage before start, then run num_beats=3 with idle cycles between beats. Required: the garbage is ignored and the run passes.
- Restart and collision: after a 1-beat fail, pulse start together with rdata_valid. Required: all status clears, that beat is discarded, and the next correct beat sequence passes.
- Saturation and num_beats=0: num_beats=0xFFFF with all-wrong data gives err_count=0xFFFF and lane_fail=0xFF. A start with num_beats=0 gives done the next cycle with pnf=1.
- Async reset asserted mid-RUN: all outputs return to reset values immediately, and no done pulse occurs.
